// File: rtl/robot_wall_if.sv
// robot_wall_if: sensor/actuator link between the world model and the robot controller
interface robot_wall_if;
  logic head;
  logic left;
  logic under;
  logic barrier;
  logic front;
  logic turn;
  logic remove;
  modport master (output head, left, under, barrier, input front, turn, remove);
  modport slave (input head, left, under, barrier, output front, turn, remove);
endinterface

// File: rtl/robot_wall_controller.sv
// robot_wall_controller: wall seeking, left-hand wall following, trash removal and target halt
module robot_wall_controller #(
  parameter int REMOVE_CYCLES = 3,
  parameter int STEP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  robot_wall_if.slave       bus,
  output logic              done,
  output logic [2:0]        fsm_state,
  output logic [STEP_W-1:0] step_count
);
  typedef enum logic [2:0] {SEEK, FOLLOW, FWD, TURN_R, REMOVE, DONE} state_t;
  localparam int RC_W = $clog2(REMOVE_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(REMOVE_CYCLES);
  state_t state, ret, nxt;
  logic p, f, t, r;
  logic [1:0] tc;
  logic [RC_W-1:0] rc;
  always_comb begin
    f = 1'b0;
    t = 1'b0;
    r = 1'b0;
    nxt = state;
    case (state)
      SEEK, FOLLOW, FWD: begin
        if (bus.under) nxt = DONE;
        else if (bus.barrier) begin
          r = 1'b1;
          nxt = REMOVE;
        end else if (state == FOLLOW && !bus.left) begin
          t = 1'b1;
          nxt = FWD;
        end else if (!bus.head) begin
          f = 1'b1;
          nxt = state == FWD ? FOLLOW : state;
        end else begin
          t = 1'b1;
          nxt = TURN_R;
        end
      end
      TURN_R: begin
        t = 1'b1;
        nxt = tc == 2'd2 ? FOLLOW : TURN_R;
      end
      REMOVE: begin
        r = rc != RC_MAX;
        nxt = rc == RC_MAX ? ret : REMOVE;
      end
      default: ;
    endcase
  end
  assign bus.front = p & f;
  assign bus.turn = p & t;
  assign bus.remove = p & r;
  assign fsm_state = state;
  // counters restart from zero on exit so entering a state always lands them on 1
  always_ff @(posedge clock) begin
    if (reset) begin
      p <= 1'b0;
      state <= SEEK;
      ret <= SEEK;
      tc <= '0;
      rc <= '0;
      step_count <= '0;
      done <= 1'b0;
    end else begin
      p <= ~p;
      if (p) begin
        state <= nxt;
        done <= nxt == DONE;
        tc <= nxt == TURN_R ? tc + 2'd1 : 2'd0;
        rc <= nxt == REMOVE ? rc + RC_W'(1) : '0;
        if (nxt == REMOVE && state != REMOVE) ret <= state == SEEK ? SEEK : FOLLOW;
        if (f && step_count != '1) step_count <= step_count + STEP_W'(1);
      end
    end
  end
endmodule

// File: doc/robot_wall_controller.md
# robot_wall_controller

Autonomous navigation controller for the pipe-cleaning robot. It sits on the robot side of the sensor/actuator interface driven by the world model, which supplies head/left/under/barrier and consumes front/turn/remove. The controller seeks a wall, then follows it with the left-hand rule. It removes trash that blocks its path and halts when the under sensor reports the target cell. It runs on the world model's two-phase cadence: sensors are updated in one cycle, and actions are consumed in the next.

## Interface
- REMOVE_CYCLES, 3: consecutive remove decisions needed to clear one trash cell (≥1)
- STEP_W, 16: width of step_count
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- head  in  1  wall or map edge directly ahead
- left  in  1  wall or map edge on robot's left
- under  in  1  robot stands on target cell
- barrier  in  1  trash directly ahead
- front  out  1  move one cell forward
- turn  out  1  rotate 90° left (counter-clockwise)
- remove  out  1  work on trash ahead
- done  out  1  target reached; sticky until reset
- fsm_state  out  3  SEEK=0, FOLLOW=1, FWD=2, TURN_R=3, REMOVE=4, DONE=5
- step_count  out  STEP_W  forward moves issued, saturating

## Operation
- Phase bit p: reset to 0, toggles on every non-reset edge. p=0 is the sense cycle and p=1 is the decision cycle.
- front/turn/remove are combinational from the registered state and the current sensors, ANDed with p. They are never high when p=0, and at most one is high at a time.
- State, counters and the return register update only on edges where p=1 (decision edges).
- SEEK, priority order:
  - under → DONE, no output.
  - barrier → remove=1, ret←SEEK, rc←1, REMOVE.
  - !head → front=1, stay.
  - else → turn=1, tc←1, TURN_R.
- FOLLOW, priority order:
  - under → DONE.
  - barrier → remove, ret←FOLLOW, REMOVE.
  - !left → turn=1, FWD.
  - !head → front=1, stay.
  - else → turn=1, tc←1, TURN_R.
- FWD (just turned left), priority order:
  - under → DONE.
  - barrier → remove, ret←FOLLOW, REMOVE.
  - !head → front=1, FOLLOW.
  - else → turn=1, tc←1, TURN_R.
- TURN_R (right turn built from three left turns):
  - turn=1 every decision cycle, tc++.
  - When tc=2 at a decision edge (third turn issued), go to FOLLOW.
  - Sensors are ignored in this state.
- REMOVE:
  - remove=1 every decision cycle.
  - If rc=REMOVE_CYCLES at a decision edge, go to ret with no output; else rc++.
  - The entering decision counts as the first remove, so exactly REMOVE_CYCLES remove pulses are issued per trash cell.
  - Sensors are ignored in this state.
- DONE:
  - All actions are 0 and done=1.
  - Held until reset, whatever the sensor inputs.
- step_count:
  - +1 on each decision edge with front=1.
  - Holds at 2^STEP_W−1 once reached.
- REMOVE_CYCLES=1: REMOVE returns to ret on the next decision without pulsing again (single pulse).

## Timing
- Reset, on any edge with reset=1 (mid-operation included):
  - State values: p=0, fsm_state=SEEK, tc=0, rc=0, ret=SEEK, step_count=0.
  - Outputs: done=0, front=turn=remove=0.
- World alignment:
  - First post-reset edge: p←1.
  - Cycle 2 after release: first decision cycle, and outputs may assert.
  - Decisions then recur every 2 cycles.
- Latency: an action is valid in the same decision cycle as the sensors it depends on, with zero registered latency. The world samples it at the end of that cycle.
- Sensor changes during p=0 have no effect on state or outputs.
- done and fsm_state are registered and change one cycle after the decision edge.

## Test plan
- Reset, then head=0 constantly:
  - front=1 on cycles 2, 4, 6…, never on odd cycles.
  - step_count=3 after the third decision.
  - fsm_state=0.
- SEEK with head=1, left=1, then head=0, left=1:
  - turn on 3 consecutive decisions, then fsm_state=1.
  - Next decision gives front.
- FOLLOW with left=0, then head=0:
  - turn, fsm_state=2, then front, fsm_state=1.
- barrier=1 held for 3 decisions, then 0:
  - remove on exactly 3 decisions (REMOVE_CYCLES=3).
  - The next decision has no action and returns to the prior state.
  - The following decision resumes motion.
- under=1 in FOLLOW with barrier=1:
  - DONE wins, no remove, done=1 next cycle.
  - Toggling any sensor keeps all actions 0.
- Reset asserted mid-REMOVE (rc=2):
  - Next cycle: fsm_state=0, step_count=0, all outputs 0.
  - First post-release action lands on cycle 2.
